// File: rtl/nv_nvdla_glb_intr_ctrl_if.sv
// nv_nvdla_glb_intr_ctrl_if: CSB register access bus between the host and the GLB interrupt controller.
interface nv_nvdla_glb_intr_ctrl_if;
  logic [11:0] reg_offset;
  logic        reg_wr_en;
  logic [31:0] reg_wr_data;
  logic [31:0] reg_rd_data;
  modport master (output reg_offset, reg_wr_en, reg_wr_data, input reg_rd_data);
  modport slave (input reg_offset, reg_wr_en, reg_wr_data, output reg_rd_data);
endinterface

// File: rtl/nv_nvdla_glb_intr_ctrl.sv
// nv_nvdla_glb_intr_ctrl: sticky per-source status, mask/set/W1C registers and registered core interrupt.
// Optional event/timeout coalescing is built when NVDLA_GLB_INTR_COALESCE_EN is defined.
module nv_nvdla_glb_intr_ctrl #(
  parameter int          NUM_SRC  = 12,
  parameter logic [7:0]  HW_MAJOR = 8'h31,
  parameter logic [15:0] HW_MINOR = 16'h3030,
  parameter int          TMO_W    = 16
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rstn,
  nv_nvdla_glb_intr_ctrl_if.slave csb,
  input  logic [NUM_SRC-1:0]     src_done,
  output logic                   core_intr
);
  logic [NUM_SRC-1:0] mask, status, pend, w1s, w1c;
  logic pend_any, wr_mask;
  logic [31:0] coal_rd;
  assign wr_mask = csb.reg_wr_en && csb.reg_offset == 12'h4;
  assign w1s = (csb.reg_wr_en && csb.reg_offset == 12'h8) ? csb.reg_wr_data[NUM_SRC-1:0] : '0;
  assign w1c = (csb.reg_wr_en && csb.reg_offset == 12'hc) ? csb.reg_wr_data[NUM_SRC-1:0] : '0;
  assign pend = status & ~mask;
  assign pend_any = |pend;
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn)
    if (!nvdla_core_rstn) begin
      mask   <= '0;
      status <= '0;
    end else begin
      if (wr_mask) mask <= csb.reg_wr_data[NUM_SRC-1:0];
      status <= (status & ~w1c) | src_done | w1s;
    end
`ifdef NVDLA_GLB_INTR_COALESCE_EN
  logic [7:0] thr, evt, evt_inc;
  logic [TMO_W-1:0] tmo, tmr;
  logic [NUM_SRC-1:0] pend_q;
  logic wr_coal, fire;
  assign wr_coal = csb.reg_wr_en && csb.reg_offset == 12'h10;
  // the rising event is counted in the same cycle it can fire, so thr of 0 or 1 adds no latency
  assign evt_inc = (|(pend & ~pend_q) && evt != 8'hff) ? evt + 8'd1 : evt;
  assign fire = pend_any && (core_intr || evt_inc >= thr || (tmo != '0 && tmr >= tmo));
  assign coal_rd = {16'(tmo), 8'd0, thr};
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn)
    if (!nvdla_core_rstn) begin
      thr       <= '0;
      tmo       <= '0;
      evt       <= '0;
      tmr       <= '0;
      pend_q    <= '0;
      core_intr <= 1'b0;
    end else begin
      if (wr_coal) begin
        thr <= csb.reg_wr_data[7:0];
        tmo <= csb.reg_wr_data[16 +: TMO_W];
      end
      pend_q    <= pend;
      evt       <= pend_any ? evt_inc : '0;
      tmr       <= !pend_any ? '0 : (!core_intr && tmr != '1) ? tmr + TMO_W'(1) : tmr;
      core_intr <= fire;
    end
`else
  assign coal_rd = '0;
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn)
    if (!nvdla_core_rstn) core_intr <= 1'b0;
    else core_intr <= pend_any;
`endif
  always_comb
    csb.reg_rd_data = csb.reg_offset == 12'h0  ? {8'd0, HW_MINOR, HW_MAJOR} :
                      csb.reg_offset == 12'h4  ? 32'(mask) :
                      csb.reg_offset == 12'hc  ? 32'(status) :
                      csb.reg_offset == 12'h10 ? coal_rd : '0;
endmodule
